pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the en/clr pair of each inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Resolves load-use hazards, branch-taken flushes, multi-cycle mult/div occupancy of EX, and syscall halt/resume.
- Keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
MD_LATENCY, 4, total cycles a mult/div instruction occupies EX (legal range 2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_r1_pos  in  5  source reg 1 index of instruction in ID
id_r2_pos  in  5  source reg 2 index of instruction in ID
id_r1_used  in  1  ID instruction reads r1
id_r2_used  in  1  ID instruction reads r2
ex_dst  in  5  destination reg index of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_md_start  in  1  EX instruction is mult/div
ex_br_taken  in  1  branch/jump resolved taken in EX
ex_halt  in  1  EX instruction is a halting syscall
go  in  1  one-cycle resume pulse (debounced)
pc_en  out  1  PC write enable
ifid_en, ifid_clr  out  1 each  IF/ID register controls
idex_en, idex_clr  out  1 each  ID/EX register controls
exmem_en, exmem_clr  out  1 each  EX/MEM register controls
memwb_en, memwb_clr  out  1 each  MEM/WB register controls
md_busy  out  1  high while in MD_WAIT
halted  out  1  high while in HALT
stall_cycles  out  CNT_W  count of cycles with pc_en==0
flush_cnt  out  CNT_W  count of branch flushes

Behaviour:
- Clocking/reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset state: RUN, md counter 0, stall_cycles=0, flush_cnt=0.
- While rst_n==0: all en and clr outputs = 0, md_busy=0, halted=0.
- Control outputs are combinational from state and inputs (same-cycle effect on the registers). State and counters are registered.
- Output patterns:
  - RUNP: every en=1, every clr=0.
  - FREEZE: every en=0, every clr=0.
  - MDSTALL: pc/ifid/idex en=0; exmem_en=1, exmem_clr=1; memwb_en=1, memwb_clr=0.
  - FLUSH: RUNP with ifid_clr=1 and idex_clr=1.
  - LDSTALL: pc_en=0, ifid_en=0; idex_en=1, idex_clr=1; exmem/memwb per RUNP.
- RUN, priority from highest:
  1. ex_halt: FREEZE -> HALT.
  2. ex_md_start: MDSTALL, load cnt=MD_LATENCY-2 -> MD_WAIT.
  3. ex_br_taken: FLUSH; flush_cnt+1.
  4. Load-use: ex_is_load && ex_dst!=0 && ((id_r1_used && id_r1_pos==ex_dst) || (id_r2_used && id_r2_pos==ex_dst)). Output LDSTALL, stay RUN.
  5. Otherwise: RUNP.
- MD_WAIT:
  - cnt!=0: MDSTALL, cnt-1.
  - cnt==0: RUNP -> RUN.
  - md inputs and ex_br_taken are ignored; the release cycle moves the mult/div on to MEM.
  - Total MDSTALL cycles = MD_LATENCY-1.
- HALT:
  - go==0: FREEZE.
  - go==1: RUNP -> RUN; the syscall advances out of EX.
  - ex_halt is ignored in HALT.
- Counters:
  - stall_cycles increments in every post-reset cycle with pc_en==0.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-operation (MD_WAIT or HALT): immediate return to RUN; cnt and counters cleared.
- Register 0 never creates a load-use hazard.

Test Plan:
- Load to r5 in EX (ex_is_load=1, ex_dst=5), ID reads r5 via r2 -> one LDSTALL cycle (pc_en=0, idex_clr=1), then RUNP. stall_cycles=1. Repeat with ex_dst=0 -> no stall.
- ex_md_start=1 with MD_LATENCY=4 -> exactly 3 MDSTALL cycles (md_busy=1 for 2 of them), then one RUNP cycle. stall_cycles=3.
- ex_br_taken=1 and load-use hazard in the same cycle -> FLUSH only (pc_en=1, ifid_clr=1, idex_clr=1). flush_cnt=1.
- ex_halt=1 -> FREEZE, halted=1 for 10 cycles. go pulse -> RUNP that cycle, halted=0 next cycle. stall_cycles=10 (the go cycle is not counted).
- rst_n low during MD_WAIT (cnt=1) -> outputs all 0 immediately. After release: RUN, RUNP, counters 0.
- Force stall_cycles to all-ones (CNT_W=4, 20 halt cycles) -> holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for the 5-stage pipeline. Drives the
// enable/clear pair of every inter-stage register plus the PC write enable,
// and resolves load-use hazards, taken-branch flushes, multi-cycle mult/div
// occupancy of EX and syscall halt/resume. Two saturating performance
// counters track stall cycles (pc_en low) and branch flushes.
//
// Parameters
//   MD_LATENCY : total cycles a mult/div occupies EX (2..255)
//   CNT_W      : width of the performance counters
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_r1_pos/id_r2_pos        : source register indices of the ID instruction
//   id_r1_used/id_r2_used      : ID instruction actually reads r1/r2
//   ex_dst, ex_is_load         : destination and load flag of the EX instruction
//   ex_md_start                : EX instruction is a mult/div
//   ex_br_taken                : branch/jump resolved taken in EX
//   ex_halt                    : EX instruction is a halting syscall
//   go                         : one-cycle resume pulse
//   pc_en, *_en, *_clr         : pipeline register controls (combinational)
//   md_busy, halted            : state flags
//   stall_cycles, flush_cnt    : saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_r1_pos,
    input  logic [4:0]       id_r2_pos,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic [4:0]       ex_dst,
    input  logic             ex_is_load,
    input  logic             ex_md_start,
    input  logic             ex_br_taken,
    input  logic             ex_halt,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic             md_busy,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        P_RUNP,
        P_FREEZE,
        P_MDSTALL,
        P_FLUSH,
        P_LDSTALL
    } pattern_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clr;
        logic idex_en;
        logic idex_clr;
        logic exmem_en;
        logic exmem_clr;
        logic memwb_en;
        logic memwb_clr;
    } ctl_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);

    state_t   state;
    logic [7:0] md_cnt;

    pattern_t pattern;
    state_t   state_nxt;
    logic     flush_evt;
    logic     load_use;
    ctl_t     ctl;

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_is_load && (ex_dst != 5'd0) &&
                      ((id_r1_used && (id_r1_pos == ex_dst)) ||
                       (id_r2_used && (id_r2_pos == ex_dst)));

    // Pattern selection and next-state decision.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        pattern   = P_RUNP;
        state_nxt = state;
        flush_evt = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (ex_halt) begin
                    pattern   = P_FREEZE;
                    state_nxt = ST_HALT;
                end else if (ex_md_start) begin
                    pattern   = P_MDSTALL;
                    state_nxt = ST_MD_WAIT;
                end else if (ex_br_taken) begin
                    pattern   = P_FLUSH;
                    flush_evt = 1'b1;
                end else if (load_use) begin
                    pattern   = P_LDSTALL;
                end
            end
            ST_MD_WAIT: begin
                // Release cycle lets the mult/div move on to MEM.
                if (md_cnt != 8'd0) begin
                    pattern = P_MDSTALL;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (go) begin
                    state_nxt = ST_RUN;
                end else begin
                    pattern = P_FREEZE;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Pattern decode; everything is forced low while reset is asserted.
    always_comb begin
        ctl = '0;
        if (rst_n) begin
            unique case (pattern)
                P_RUNP:    ctl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
                P_FREEZE:  ctl = '0;
                P_MDSTALL: ctl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
                P_FLUSH:   ctl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
                P_LDSTALL: ctl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
                default:   ctl = '0;
            endcase
        end
    end

    assign pc_en     = ctl.pc_en;
    assign ifid_en   = ctl.ifid_en;
    assign ifid_clr  = ctl.ifid_clr;
    assign idex_en   = ctl.idex_en;
    assign idex_clr  = ctl.idex_clr;
    assign exmem_en  = ctl.exmem_en;
    assign exmem_clr = ctl.exmem_clr;
    assign memwb_en  = ctl.memwb_en;
    assign memwb_clr = ctl.memwb_clr;

    assign md_busy = (state == ST_MD_WAIT);
    assign halted  = (state == ST_HALT);

    // State, mult/div countdown and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            md_cnt       <= 8'd0;
            stall_cycles <= '0;
            flush_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_nxt;
            if (state == ST_RUN && !ex_halt && ex_md_start) begin
                md_cnt <= MD_LOAD;
            end else if (state == ST_MD_WAIT && md_cnt != 8'd0) begin
                md_cnt <= md_cnt - 8'd1;
            end
            if (!ctl.pc_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_evt && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. A default instance (MD_LATENCY=4,
// CNT_W=32) and a narrow instance (CNT_W=4) share all inputs; the narrow one
// exercises counter saturation. Inputs change 1 time unit after the rising
// edge, combinational controls are sampled on the falling edge and counters
// just after the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_r1_pos, id_r2_pos, ex_dst;
    logic       id_r1_used, id_r2_used, ex_is_load, ex_md_start;
    logic       ex_br_taken, ex_halt, go;

    logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic        exmem_en, exmem_clr, memwb_en, memwb_clr;
    logic        md_busy, halted;
    logic [31:0] stall_cycles, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_clr, s_idex_en, s_idex_clr;
    logic        s_exmem_en, s_exmem_clr, s_memwb_en, s_memwb_clr;
    logic        s_md_busy, s_halted;
    logic [3:0]  s_stall_cycles, s_flush_cnt;

    // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr}
    localparam logic [8:0] RUNP    = 9'b1_10_10_10_10;
    localparam logic [8:0] FREEZE  = 9'b0_00_00_00_00;
    localparam logic [8:0] MDSTALL = 9'b0_00_00_11_10;
    localparam logic [8:0] FLUSH   = 9'b1_11_11_10_10;
    localparam logic [8:0] LDSTALL = 9'b0_00_11_10_10;

    logic [8:0] ctl_v;
    assign ctl_v = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                    exmem_en, exmem_clr, memwb_en, memwb_clr};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load), .ex_md_start(ex_md_start),
        .ex_br_taken(ex_br_taken), .ex_halt(ex_halt), .go(go),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .idex_en(idex_en), .idex_clr(idex_clr),
        .exmem_en(exmem_en), .exmem_clr(exmem_clr),
        .memwb_en(memwb_en), .memwb_clr(memwb_clr),
        .md_busy(md_busy), .halted(halted),
        .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load), .ex_md_start(ex_md_start),
        .ex_br_taken(ex_br_taken), .ex_halt(ex_halt), .go(go),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_clr(s_ifid_clr),
        .idex_en(s_idex_en), .idex_clr(s_idex_clr),
        .exmem_en(s_exmem_en), .exmem_clr(s_exmem_clr),
        .memwb_en(s_memwb_en), .memwb_clr(s_memwb_clr),
        .md_busy(s_md_busy), .halted(s_halted),
        .stall_cycles(s_stall_cycles), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_r1_pos   = 5'd0;
        id_r2_pos   = 5'd0;
        id_r1_used  = 1'b0;
        id_r2_used  = 1'b0;
        ex_dst      = 5'd0;
        ex_is_load  = 1'b0;
        ex_md_start = 1'b0;
        ex_br_taken = 1'b0;
        ex_halt     = 1'b0;
        go          = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset state
        @(negedge clk);
        check("rst_ctl", {23'd0, ctl_v}, {23'd0, FREEZE});
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_flush", flush_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_runp", {23'd0, ctl_v}, {23'd0, RUNP});
        tick();

        // Load-use via r2
        do_reset();
        ex_is_load = 1'b1; ex_dst = 5'd5; id_r2_used = 1'b1; id_r2_pos = 5'd5;
        @(negedge clk);
        check("ld_r2_stall", {23'd0, ctl_v}, {23'd0, LDSTALL});
        tick();
        clear_inputs();
        @(negedge clk);
        check("ld_after_runp", {23'd0, ctl_v}, {23'd0, RUNP});
        check("ld_stall_cnt", stall_cycles, 32'd1);
        tick();
        // Load to r0: no hazard
        ex_is_load = 1'b1; ex_dst = 5'd0; id_r2_used = 1'b1; id_r2_pos = 5'd0;
        @(negedge clk);
        check("ld_r0_nostall", {23'd0, ctl_v}, {23'd0, RUNP});
        tick();
        check("ld_r0_cnt", stall_cycles, 32'd1);
        // Matching index but operand unused: no hazard
        clear_inputs();
        ex_is_load = 1'b1; ex_dst = 5'd7; id_r1_pos = 5'd7; id_r2_pos = 5'd7;
        @(negedge clk);
        check("ld_unused_nostall", {23'd0, ctl_v}, {23'd0, RUNP});
        tick();
        // Load-use via r1
        id_r1_used = 1'b1;
        @(negedge clk);
        check("ld_r1_stall", {23'd0, ctl_v}, {23'd0, LDSTALL});
        tick();
        clear_inputs();
        check("ld_r1_cnt", stall_cycles, 32'd2);

        // Mult/div occupancy; md/branch inputs held high are ignored in MD_WAIT
        do_reset();
        ex_md_start = 1'b1;
        @(negedge clk);
        check("md_c0_ctl", {23'd0, ctl_v}, {23'd0, MDSTALL});
        check("md_c0_busy", {31'd0, md_busy}, 32'd0);
        tick();
        ex_br_taken = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check($sformatf("md_c%0d_ctl", i), {23'd0, ctl_v}, {23'd0, MDSTALL});
            check($sformatf("md_c%0d_busy", i), {31'd0, md_busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        check("md_release_ctl", {23'd0, ctl_v}, {23'd0, RUNP});
        tick();
        clear_inputs();
        @(negedge clk);
        check("md_after_ctl", {23'd0, ctl_v}, {23'd0, RUNP});
        check("md_after_busy", {31'd0, md_busy}, 32'd0);
        check("md_stall_cnt", stall_cycles, 32'd3);
        check("md_flush_cnt", flush_cnt, 32'd0);
        tick();

        // Branch taken beats a simultaneous load-use hazard
        do_reset();
        ex_br_taken = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd9;
        id_r1_used = 1'b1; id_r1_pos = 5'd9;
        @(negedge clk);
        check("br_ld_ctl", {23'd0, ctl_v}, {23'd0, FLUSH});
        tick();
        clear_inputs();
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cycles, 32'd0);

        // Halt for 10 cycles, then go; ex_halt stays high (ignored in HALT)
        do_reset();
        ex_halt = 1'b1;
        @(negedge clk);
        check("halt_c0_ctl", {23'd0, ctl_v}, {23'd0, FREEZE});
        check("halt_c0_flag", {31'd0, halted}, 32'd0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("halt_c%0d_ctl", i), {23'd0, ctl_v}, {23'd0, FREEZE});
            check($sformatf("halt_c%0d_flag", i), {31'd0, halted}, 32'd1);
            tick();
        end
        go = 1'b1;
        @(negedge clk);
        check("halt_go_ctl", {23'd0, ctl_v}, {23'd0, RUNP});
        check("halt_go_flag", {31'd0, halted}, 32'd1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("halt_after_flag", {31'd0, halted}, 32'd0);
        check("halt_after_ctl", {23'd0, ctl_v}, {23'd0, RUNP});
        check("halt_stall_cnt", stall_cycles, 32'd10);
        check("halt_small_cnt", {28'd0, s_stall_cycles}, 32'd10);
        tick();

        // Reset asserted in MD_WAIT with cnt==1
        do_reset();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick();
        @(negedge clk);
        check("mdrst_pre_ctl", {23'd0, ctl_v}, {23'd0, MDSTALL});
        #1;
        rst_n = 1'b0;
        #1;
        check("mdrst_ctl", {23'd0, ctl_v}, {23'd0, FREEZE});
        check("mdrst_busy", {31'd0, md_busy}, 32'd0);
        check("mdrst_stall", stall_cycles, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mdrst_after_ctl", {23'd0, ctl_v}, {23'd0, RUNP});
        check("mdrst_after_busy", {31'd0, md_busy}, 32'd0);
        check("mdrst_after_stall", stall_cycles, 32'd0);
        check("mdrst_after_flush", flush_cnt, 32'd0);
        tick();

        // Stall counter saturation: 20 frozen cycles
        do_reset();
        ex_halt = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall_small", {28'd0, s_stall_cycles}, 32'd15);
        check("sat_stall_main", stall_cycles, 32'd20);
        ex_halt = 1'b0;
        go = 1'b1;
        tick();
        clear_inputs();
        check("sat_stall_hold", {28'd0, s_stall_cycles}, 32'd15);

        // Flush counter saturation: 17 taken branches
        do_reset();
        ex_br_taken = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        clear_inputs();
        check("sat_flush_small", {28'd0, s_flush_cnt}, 32'd15);
        check("sat_flush_main", flush_cnt, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
